// File: rtl/fwrisc_fetch_pkg.sv
// fwrisc_fetch_pkg -- shared state, entry types and reset vector for the FWRISC fetch unit.
// Rev 1.0
`default_nettype none

package fwrisc_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALL   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } fetch_entry_t;

  // RVC encodings are every opcode whose two low bits are not 2'b11.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwrisc_fetch_fifo.sv
// fwrisc_fetch_fifo -- small instruction buffer between fetch and decode (push/pop/flush/count).
// Rev 1.0
`default_nettype none

module fwrisc_fetch_fifo
  import fwrisc_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fwrisc_fetch_ctrl.sv
// fwrisc_fetch_ctrl -- instruction fetch FSM: memory request, address advance, redirect and buffering.
// Rev 1.0
`default_nettype none

module fwrisc_fetch_ctrl
  import fwrisc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic        iready,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      target_q, target_d;
  logic             push;
  logic             pop;
  logic             idata_c;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_if_push;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign idata_c       = is_compressed(idata[1:0]);
  assign ivalid        = !reset && (state_q != STALL);
  assign iaddr         = addr_q;
  assign fetch_valid   = !reset && (count != '0);
  assign pop           = fetch_valid && decode_ready;
  assign count_if_push = count + CNT_W'(1) - CNT_W'(pop);
  assign push_entry    = {addr_q, idata, idata_c};

  assign instr   = fetch_valid ? head.instr : '0;
  assign instr_c = fetch_valid ? head.c     : 1'b0;
  assign pc      = fetch_valid ? head.pc    : '0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    target_d = target_q;
    push     = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (iready) begin
            addr_d = redirect_pc;
          end else begin
            // Request is already on the bus; keep iaddr and swallow its response.
            target_d = redirect_pc;
            state_d  = DISCARD;
          end
        end else if (iready) begin
          push   = 1'b1;
          addr_d = addr_q + (idata_c ? 32'd2 : 32'd4);
          if (count_if_push == CNT_W'(BUF_DEPTH)) state_d = STALL;
        end
      end
      STALL: begin
        if (redirect_valid) begin
          addr_d  = redirect_pc;
          state_d = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_valid) target_d = redirect_pc;
        if (iready) begin
          addr_d  = redirect_valid ? redirect_pc : target_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      addr_q   <= RESET_VECTOR;
      target_q <= RESET_VECTOR;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
    end
  end

  fwrisc_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_fetch_ctrl.sv
// tb_fwrisc_fetch_ctrl -- directed bench with an expected-instruction queue checked at decode.
// Rev 1.0
`default_nettype none

module tb_fwrisc_fetch_ctrl;
  import fwrisc_fetch_pkg::*;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] pc;

  fetch_entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fwrisc_fetch_ctrl #(
    .RESET_VECTOR (32'h8000_0000),
    .BUF_DEPTH    (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .iaddr          (iaddr),
    .ivalid         (ivalid),
    .iready         (iready),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .decode_ready   (decode_ready),
    .instr          (instr),
    .instr_c        (instr_c),
    .pc             (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs at negedge, sample just after, update the scoreboard.
  task automatic step(input logic ir, input logic [31:0] d, input logic dr,
                      input logic rv, input logic [31:0] rpc,
                      input logic exp_iv, input logic [31:0] exp_addr,
                      input logic exp_push, input string tag);
    fetch_entry_t e;
    @(negedge clock);
    iready = ir; idata = d; decode_ready = dr; redirect_valid = rv; redirect_pc = rpc;
    #1;
    chk({tag, " ivalid"}, 32'(ivalid), 32'(exp_iv));
    if (exp_iv) chk({tag, " iaddr"}, iaddr, exp_addr);
    if (fetch_valid) begin
      if (exp_q.size() == 0) begin
        chk({tag, " unexpected fetch_valid"}, 32'(fetch_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk({tag, " pc"}, pc, e.pc);
        chk({tag, " instr"}, instr, e.instr);
        chk({tag, " instr_c"}, 32'(instr_c), 32'(e.c));
        if (dr) void'(exp_q.pop_front());
      end
    end
    if (rv) exp_q.delete();
    if (exp_push) begin
      e.pc = exp_addr; e.instr = d; e.c = (d[1:0] != 2'b11);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; iready = 1'b1; idata = 32'h0000_02B7;
    decode_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset ivalid", 32'(ivalid), 32'd0);
    chk("reset fetch_valid", 32'(fetch_valid), 32'd0);
    chk("reset instr", instr, 32'd0);
    chk("reset instr_c", 32'(instr_c), 32'd0);
    chk("reset pc", pc, 32'd0);
    @(posedge clock); #1; reset = 1'b0;

    // Basic 32-bit and compressed fetch with decode always ready.
    step(1, 32'h0000_02B7, 1, 0, 0, 1, 32'h8000_0000, 1, "lui0");
    step(1, 32'h0000_02B7, 1, 0, 0, 1, 32'h8000_0004, 1, "lui1");
    chk("lui latency fetch_valid", 32'(fetch_valid), 32'd1);
    step(1, 32'h0000_4501, 1, 0, 0, 1, 32'h8000_0008, 1, "cli");
    step(1, 32'h0000_02B7, 1, 0, 0, 1, 32'h8000_000A, 1, "after_c");
    step(0, JUNK,          1, 0, 0, 1, 32'h8000_000E, 0, "drain0");

    // Fill the buffer with decode stalled, then release one entry.
    step(1, 32'h0000_0013, 0, 0, 0, 1, 32'h8000_000E, 1, "fill0");
    step(1, 32'h0010_0093, 0, 0, 0, 1, 32'h8000_0012, 1, "fill1");
    step(1, JUNK,          0, 0, 0, 0, 32'h0,         0, "stall0");
    step(1, JUNK,          0, 0, 0, 0, 32'h0,         0, "stall1");
    step(1, JUNK,          1, 0, 0, 0, 32'h0,         0, "stall_pop");
    step(0, JUNK,          0, 0, 0, 1, 32'h8000_0016, 0, "unstall");
    step(1, 32'h0020_0113, 1, 0, 0, 1, 32'h8000_0016, 1, "resume");
    step(0, JUNK,          1, 0, 0, 1, 32'h8000_001A, 0, "drain1");

    // Redirect while the request waits; the late response must be dropped.
    step(0, JUNK,          1, 1, 32'h8000_1000, 1, 32'h8000_001A, 0, "disc_rd");
    step(0, JUNK,          1, 0, 0,             1, 32'h8000_001A, 0, "disc_hold0");
    step(0, JUNK,          1, 0, 0,             1, 32'h8000_001A, 0, "disc_hold1");
    step(1, JUNK,          1, 0, 0,             1, 32'h8000_001A, 0, "disc_drop");
    step(1, 32'h0000_0517, 1, 0, 0,             1, 32'h8000_1000, 1, "disc_new");
    chk("disc no stale fetch_valid", 32'(fetch_valid), 32'd0);
    step(0, JUNK,          1, 0, 0,             1, 32'h8000_1004, 0, "disc_pop");

    // Redirect on a full (stalled) buffer with a same-cycle pop.
    step(1, 32'h0030_0193, 0, 0, 0,             1, 32'h8000_1004, 1, "full0");
    step(1, 32'h0040_0213, 0, 0, 0,             1, 32'h8000_1008, 1, "full1");
    step(1, JUNK,          1, 1, 32'h8000_2000, 0, 32'h0,         0, "stall_rd");
    step(1, 32'h0050_0293, 0, 0, 0,             1, 32'h8000_2000, 1, "after_stall_rd");
    chk("stall_rd flushed", 32'(fetch_valid), 32'd0);
    // Redirect with pop and accepted push in the same cycle.
    step(1, 32'h0060_0313, 1, 1, 32'h8000_3000, 1, 32'h8000_2004, 0, "pp_rd");
    step(1, 32'h0000_4505, 1, 0, 0,             1, 32'h8000_3000, 1, "pp_new");
    chk("pp_rd flushed", 32'(fetch_valid), 32'd0);
    step(0, JUNK,          1, 0, 0,             1, 32'h8000_3002, 0, "pp_pop");

    // Two redirects during DISCARD: the last target wins.
    step(0, JUNK,          1, 1, 32'h8000_4000, 1, 32'h8000_3002, 0, "dd_rd0");
    step(0, JUNK,          1, 1, 32'h8000_5000, 1, 32'h8000_3002, 0, "dd_rd1");
    step(1, JUNK,          1, 0, 0,             1, 32'h8000_3002, 0, "dd_drop");
    step(1, JUNK,          1, 1, 32'hFFFF_FFFC, 1, 32'h8000_5000, 0, "wrap_rd");

    // Address wrap past 2^32.
    step(1, 32'h0070_0393, 1, 0, 0,             1, 32'hFFFF_FFFC, 1, "wrap_top");
    step(0, JUNK,          1, 0, 0,             1, 32'h0000_0000, 0, "wrap_zero");
    step(1, 32'h0080_0413, 0, 0, 0,             1, 32'h0000_0000, 1, "pre_rst");

    // Reset mid-request with a late iready and a non-empty buffer.
    @(posedge clock); #1;
    reset = 1'b1; iready = 1'b1; idata = JUNK; decode_ready = 1'b1;
    #1;
    chk("midrst ivalid", 32'(ivalid), 32'd0);
    chk("midrst fetch_valid", 32'(fetch_valid), 32'd0);
    exp_q.delete();
    @(negedge clock); #1;
    chk("midrst held ivalid", 32'(ivalid), 32'd0);
    chk("midrst pc", pc, 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    step(1, 32'h0000_02B7, 1, 0, 0, 1, 32'h8000_0000, 1, "rst2");
    chk("rst2 fetch_valid", 32'(fetch_valid), 32'd0);
    step(0, JUNK,          1, 0, 0, 1, 32'h8000_0004, 0, "rst2_pop");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
